// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 register file and its clear sequencer.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks ptr over x1..x(NREGS-1) zeroing each entry, and flags
// writeback writes that arrive while the sweep owns the array.
//   state | meaning
//   IDLE  | array open to writeback; clr_req starts a sweep
//   SWEEP | one register cleared per cycle, writes dropped
module regfile_clr_seq
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_drop,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    ptr_d   = AW'(1);
                end
            end
            SWEEP: begin
                // x0 is never swept; a write aimed at it is silently discarded anyway
                drop_d = wr_en && (wr_addr != AW'(REG_ZERO));
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign clr_busy   = (state_q == SWEEP);
    assign sweep_en   = (state_q == SWEEP);
    assign sweep_addr = ptr_q;
    assign clr_done   = done_q;
    assign wr_drop    = drop_q;

endmodule

// File: rtl/regfile_multiport.sv
// XLEN x NREGS architectural register file: NREAD combinational read ports,
// one write port, hardwired x0, optional write forwarding and busy scoreboard.
module regfile_multiport
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_drop
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             sweep_en;
    logic [AW-1:0]    sweep_addr;
    logic             wr_ok;
    logic             sb_ok;

    regfile_clr_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_drop    (wr_drop),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr)
    );

    assign wr_ok = wr_en && (wr_addr != AW'(REG_ZERO)) && !sweep_en;
    assign sb_ok = sb_set && (sb_addr != AW'(REG_ZERO)) && !sweep_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (sweep_en) begin
            regs[sweep_addr] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Set is applied after the write-clear so a newer producer keeps its busy mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (sweep_en) begin
            busy[sweep_addr] <= 1'b0;
        end else begin
            if (wr_ok) begin
                busy[wr_addr] <= 1'b0;
            end
            if (sb_ok) begin
                busy[sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          fwd;

        assign addr    = rd_addr[i*AW +: AW];
        assign is_zero = (addr == AW'(REG_ZERO));
        // Forwarding is independent of the sweep state: reads see the in-flight data.
        assign fwd     = (BYPASS != 0) && wr_en && (addr == wr_addr) && !is_zero;

        assign rd_data[i*XLEN +: XLEN] = is_zero ? '0 : (fwd ? wr_data : regs[addr]);
        assign rd_busy[i]              = !is_zero && !fwd && busy[addr];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: a forwarding instance and a
// non-forwarding instance share stimulus; expectations are queued and drained.
module tb_regfile_multiport;
    import rv_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREAD*AW-1:0]   rd_addr = '0;
    logic                  wr_en = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [XLEN-1:0]       wr_data = '0;
    logic                  sb_set = 1'b0;
    logic [AW-1:0]         sb_addr = '0;
    logic                  clr_req = 1'b0;

    logic [NREAD*XLEN-1:0] rd_data, nb_rd_data;
    logic [NREAD-1:0]      rd_busy, nb_rd_busy;
    logic                  clr_busy, clr_done, wr_drop;
    logic                  nb_clr_busy, nb_clr_done, nb_wr_drop;

    regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_req(clr_req), .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .wr_drop(nb_wr_drop)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_D0, K_D1, K_B0, K_B1, K_CBUSY, K_CDONE, K_DROP,
        K_NB_D0, K_NB_D1, K_NB_B0, K_NB_B1, K_NB_CBUSY, K_NB_CDONE, K_NB_DROP
    } kind_t;

    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_t kind);
        case (kind)
            K_D0:       return rd_data[31:0];
            K_D1:       return rd_data[63:32];
            K_B0:       return {31'b0, rd_busy[0]};
            K_B1:       return {31'b0, rd_busy[1]};
            K_CBUSY:    return {31'b0, clr_busy};
            K_CDONE:    return {31'b0, clr_done};
            K_DROP:     return {31'b0, wr_drop};
            K_NB_D0:    return nb_rd_data[31:0];
            K_NB_D1:    return nb_rd_data[63:32];
            K_NB_B0:    return {31'b0, nb_rd_busy[0]};
            K_NB_B1:    return {31'b0, nb_rd_busy[1]};
            K_NB_CBUSY: return {31'b0, nb_clr_busy};
            K_NB_CDONE: return {31'b0, nb_clr_done};
            default:    return {31'b0, nb_wr_drop};
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_t kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        logic [AW-1:0] p0, p1;
        p0 = AW'(a0);
        p1 = AW'(a1);
        rd_addr = {p1, p0};
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int n_busy, n_done;

    initial begin
        repeat (2) @(negedge clk);
        expect_val("rst_clr_busy", K_CBUSY, 0);
        expect_val("rst_clr_done", K_CDONE, 0);
        expect_val("rst_wr_drop", K_DROP, 0);
        drain();
        rst_n = 1'b1;

        // every register reads zero and not busy out of reset
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            set_rd(a, NREGS - 1 - a);
            expect_val("rst_d0", K_D0, 0);
            expect_val("rst_d1", K_D1, 0);
            expect_val("rst_b0", K_B0, 0);
            expect_val("rst_b1", K_B1, 0);
            drain();
        end

        // same-cycle forwarding vs stored-only read
        @(negedge clk);
        set_rd(5, 0);
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        expect_val("byp_same", K_D0, 32'hDEADBEEF);
        expect_val("nobyp_same", K_NB_D0, 0);
        drain();
        @(negedge clk);
        wr_en = 1'b0;
        expect_val("byp_next", K_D0, 32'hDEADBEEF);
        expect_val("nobyp_next", K_NB_D0, 32'hDEADBEEF);
        drain();

        // x0 writes vanish, and x0 is never forwarded
        @(negedge clk);
        set_rd(0, 0);
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        expect_val("x0_same", K_D0, 0);
        drain();
        @(negedge clk);
        wr_en = 1'b0;
        expect_val("x0_next", K_D0, 0);
        expect_val("x0_next_nb", K_NB_D1, 0);
        drain();

        // scoreboard set vs write-clear priority
        @(negedge clk);
        set_rd(0, 7);
        sb_set = 1'b1; sb_addr = 7;
        expect_val("sb_pre", K_B1, 0);
        drain();
        @(negedge clk);
        sb_set = 1'b0;
        expect_val("sb_set", K_B1, 1);
        expect_val("sb_set_nb", K_NB_B1, 1);
        drain();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h70;
        sb_set = 1'b1; sb_addr = 7;
        expect_val("sb_fwd_busy", K_B1, 0);
        expect_val("sb_fwd_data", K_D1, 32'h70);
        expect_val("sb_nb_busy", K_NB_B1, 1);
        drain();
        @(negedge clk);
        wr_en = 1'b0; sb_set = 1'b0;
        expect_val("sb_set_wins", K_B1, 1);
        expect_val("sb_wr_data", K_D1, 32'h70);
        drain();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h71;
        expect_val("sb_clr_fwd", K_B1, 0);
        drain();
        @(negedge clk);
        wr_en = 1'b0;
        expect_val("sb_cleared", K_B1, 0);
        expect_val("sb_cleared_nb", K_NB_B1, 0);
        expect_val("sb_clr_data", K_D1, 32'h71);
        drain();

        // fill x1..x31 with their index and mark x9 busy
        for (int a = 1; a < NREGS; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = a;
        end
        @(negedge clk);
        wr_en = 1'b0;
        sb_set = 1'b1; sb_addr = 9;
        @(negedge clk);
        sb_set = 1'b0;
        for (int a = 1; a < NREGS; a++) begin
            @(negedge clk);
            set_rd(a, NREGS - a);
            expect_val("fill_d0", K_D0, a);
            expect_val("fill_d1", K_NB_D1, NREGS - a);
            drain();
        end
        @(negedge clk);
        set_rd(9, 0);
        expect_val("fill_busy9", K_B0, 1);
        drain();

        // clear sweep with a dropped write in the middle
        @(negedge clk);
        set_rd(0, 0);
        clr_req = 1'b1;
        expect_val("req_no_comb", K_CBUSY, 0);
        drain();
        for (int c = 0; c < NREGS - 1; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
            wr_en   = (c == 10);
            wr_addr = 3;
            wr_data = 32'hABC;
            expect_val("sweep_busy", K_CBUSY, 1);
            expect_val("sweep_busy_nb", K_NB_CBUSY, 1);
            expect_val("sweep_done", K_CDONE, 0);
            expect_val("sweep_drop", K_DROP, (c == 11) ? 1 : 0);
            drain();
        end
        @(negedge clk);
        wr_en = 1'b0;
        expect_val("end_busy", K_CBUSY, 0);
        expect_val("end_done", K_CDONE, 1);
        expect_val("end_done_nb", K_NB_CDONE, 1);
        expect_val("end_drop", K_DROP, 0);
        drain();
        @(negedge clk);
        expect_val("done_pulse", K_CDONE, 0);
        expect_val("drop_nb", K_NB_DROP, 0);
        drain();
        for (int a = 1; a < NREGS; a++) begin
            @(negedge clk);
            set_rd(a, a);
            expect_val("swept_d0", K_D0, 0);
            expect_val("swept_b0", K_B0, 0);
            expect_val("swept_nb_b0", K_NB_B0, 0);
            drain();
        end

        // reset during a sweep aborts it
        write_reg(20, 32'h2020);
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 25;
        @(negedge clk);
        sb_set = 1'b0;
        set_rd(20, 25);
        expect_val("pre_abort_b1", K_B1, 1);
        drain();
        @(negedge clk);
        clr_req = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
        end
        expect_val("mid_sweep_d0", K_D0, 32'h2020);
        drain();
        #2;
        rst_n = 1'b0;
        expect_val("abort_busy", K_CBUSY, 0);
        expect_val("abort_done", K_CDONE, 0);
        expect_val("abort_drop", K_DROP, 0);
        expect_val("abort_d0", K_D0, 0);
        expect_val("abort_b1", K_B1, 0);
        drain();
        repeat (2) begin
            @(negedge clk);
            expect_val("held_done", K_CDONE, 0);
            drain();
        end
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("post_rst_done", K_CDONE, 0);
        expect_val("post_rst_busy", K_CBUSY, 0);
        drain();

        @(negedge clk);
        clr_req = 1'b1;
        n_busy = 0;
        n_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            clr_req = 1'b0;
            #1;
            if (clr_busy) n_busy++;
            if (clr_done) n_done++;
        end
        check("resweep_len", n_busy, NREGS - 1);
        check("resweep_done", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
